demux4_seq: RTL and testbench

Sequential 1->4 demultiplexer that reconstructs four parallel lanes from a time-multiplexed stream, i.e. the receive end of a mux4 whose sel is driven by a rotating 2-bit lane counter. A frame marker on lane 0 aligns the block. It captures one lane per valid beat, publishes a complete 4-lane word with a one-cycle strobe, and flags alignment errors. It sits downstream of the mux4 stage and feeds parallel consumers.

---
 rtl/demux4_seq_if.sv | 35 +++
 rtl/demux4_seq.sv | 109 ++++++++++
 tb/tb_demux4_seq.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/demux4_seq_if.sv
//==============================================================================
// Module : demux4_seq_if
// Brief  : Stream-in / parallel-word-out bundle for the 1->4 sequential demux.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

interface demux4_seq_if #(
    parameter int W = 1
);
    logic [W-1:0] din;
    logic         din_valid;
    logic         frame;
    logic [W-1:0] q0;
    logic [W-1:0] q1;
    logic [W-1:0] q2;
    logic [W-1:0] q3;
    logic [1:0]   sel;
    logic         locked;
    logic         word_valid;
    logic         sync_err;
    logic [3:0]   err_count;

    modport master (
        output din, din_valid, frame,
        input  q0, q1, q2, q3, sel, locked, word_valid, sync_err, err_count
    );

    modport slave (
        input  din, din_valid, frame,
        output q0, q1, q2, q3, sel, locked, word_valid, sync_err, err_count
    );
endinterface

`default_nettype wire

// File: rtl/demux4_seq.sv
//==============================================================================
// Module : demux4_seq
// Brief  : Rebuilds four parallel lanes from a framed, time-multiplexed stream.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module demux4_seq #(
    parameter int W = 1
) (
    input  wire logic     clk,
    input  wire logic     rst,
    demux4_seq_if.slave   bus
);
    typedef enum logic [0:0] {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t       state_q;
    logic [1:0]   sel_q;
    logic [W-1:0] shadow0_q;
    logic [W-1:0] shadow1_q;
    logic [W-1:0] shadow2_q;
    logic [W-1:0] q0_q;
    logic [W-1:0] q1_q;
    logic [W-1:0] q2_q;
    logic [W-1:0] q3_q;
    logic         word_valid_q;
    logic         sync_err_q;
    logic [3:0]   err_count_q;
    logic [3:0]   err_count_d;

    assign err_count_d = (err_count_q == 4'hF) ? err_count_q : err_count_q + 4'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= HUNT;
            sel_q        <= 2'd0;
            shadow0_q    <= '0;
            shadow1_q    <= '0;
            shadow2_q    <= '0;
            q0_q         <= '0;
            q1_q         <= '0;
            q2_q         <= '0;
            q3_q         <= '0;
            word_valid_q <= 1'b0;
            sync_err_q   <= 1'b0;
            err_count_q  <= 4'd0;
        end else begin
            word_valid_q <= 1'b0;
            sync_err_q   <= 1'b0;
            if (bus.din_valid) begin
                case (state_q)
                    HUNT: begin
                        if (bus.frame) begin
                            shadow0_q <= bus.din;
                            sel_q     <= 2'd1;
                            state_q   <= RUN;
                        end
                    end
                    default: begin
                        // Priority order matters: a marker on lane 3 realigns rather than completing.
                        if (bus.frame && (sel_q != 2'd0)) begin
                            sync_err_q  <= 1'b1;
                            err_count_q <= err_count_d;
                            shadow0_q   <= bus.din;
                            sel_q       <= 2'd1;
                        end else if (!bus.frame && (sel_q == 2'd0)) begin
                            sync_err_q  <= 1'b1;
                            err_count_q <= err_count_d;
                            sel_q       <= 2'd0;
                            state_q     <= HUNT;
                        end else if (sel_q == 2'd1) begin
                            shadow1_q <= bus.din;
                            sel_q     <= 2'd2;
                        end else if (sel_q == 2'd2) begin
                            shadow2_q <= bus.din;
                            sel_q     <= 2'd3;
                        end else if (sel_q == 2'd3) begin
                            q0_q         <= shadow0_q;
                            q1_q         <= shadow1_q;
                            q2_q         <= shadow2_q;
                            q3_q         <= bus.din;
                            word_valid_q <= 1'b1;
                            sel_q        <= 2'd0;
                        end else begin
                            shadow0_q <= bus.din;
                            sel_q     <= 2'd1;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.q0         = q0_q;
    assign bus.q1         = q1_q;
    assign bus.q2         = q2_q;
    assign bus.q3         = q3_q;
    assign bus.sel        = sel_q;
    assign bus.locked     = (state_q == RUN);
    assign bus.word_valid = word_valid_q;
    assign bus.sync_err   = sync_err_q;
    assign bus.err_count  = err_count_q;

endmodule

`default_nettype wire

// File: tb/tb_demux4_seq.sv
//==============================================================================
// Module : tb_demux4_seq
// Brief  : Scoreboard bench for demux4_seq: model predicts words, monitor pops.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_demux4_seq;
    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    demux4_seq_if #(.W(1)) bus ();

    demux4_seq #(.W(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    bit         m_run;
    int         m_sel;
    logic       m_sh [3];
    int         m_err;
    logic [3:0] sb_q [$];
    int         n_wv;
    int         n_serr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Monitor: every word_valid pulse must match the oldest predicted word.
    always @(negedge clk) begin
        if (bus.sync_err === 1'b1) n_serr++;
        if (bus.word_valid === 1'b1) begin
            n_wv++;
            if (sb_q.size() == 0) begin
                chk("wv_unexpected", 32'd1, 32'd0);
            end else begin
                logic [3:0] e;
                e = sb_q.pop_front();
                chk("word", {28'd0, bus.q3, bus.q2, bus.q1, bus.q0}, {28'd0, e});
            end
        end
    end

    task automatic model_reset();
        m_run = 1'b0;
        m_sel = 0;
        for (int i = 0; i < 3; i++) m_sh[i] = 1'b0;
        m_err = 0;
        sb_q.delete();
    endtask

    task automatic beat(input logic f, input logic d);
        bit exp_wv;
        bit exp_se;
        exp_wv = 1'b0;
        exp_se = 1'b0;
        chk("sel", {30'd0, bus.sel}, m_sel);
        chk("locked", {31'd0, bus.locked}, {31'd0, m_run});
        bus.din_valid = 1'b1;
        bus.frame     = f;
        bus.din       = d;
        if (!m_run) begin
            if (f) begin
                m_sh[0] = d; m_sel = 1; m_run = 1'b1;
            end
        end else if (f && m_sel != 0) begin
            exp_se = 1'b1; m_err++; m_sh[0] = d; m_sel = 1;
        end else if (!f && m_sel == 0) begin
            exp_se = 1'b1; m_err++; m_sel = 0; m_run = 1'b0;
        end else if (m_sel == 1 || m_sel == 2) begin
            m_sh[m_sel] = d; m_sel++;
        end else if (m_sel == 3) begin
            sb_q.push_back({d, m_sh[2], m_sh[1], m_sh[0]});
            exp_wv = 1'b1; m_sel = 0;
        end else begin
            m_sh[0] = d; m_sel = 1;
        end
        @(posedge clk);
        #1;
        bus.din_valid = 1'b0;
        bus.frame     = 1'b0;
        bus.din       = 1'b0;
        chk("word_valid", {31'd0, bus.word_valid}, {31'd0, exp_wv});
        chk("sync_err", {31'd0, bus.sync_err}, {31'd0, exp_se});
        chk("err_count", {28'd0, bus.err_count}, (m_err > 15) ? 15 : m_err);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            chk("idle_wv", {31'd0, bus.word_valid}, 32'd0);
            chk("idle_sel", {30'd0, bus.sel}, m_sel);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_q"}, {28'd0, bus.q3, bus.q2, bus.q1, bus.q0}, 32'd0);
        chk({tag, "_sel"}, {30'd0, bus.sel}, 32'd0);
        chk({tag, "_locked"}, {31'd0, bus.locked}, 32'd0);
        chk({tag, "_wv"}, {31'd0, bus.word_valid}, 32'd0);
        chk({tag, "_serr"}, {31'd0, bus.sync_err}, 32'd0);
        chk({tag, "_errcnt"}, {28'd0, bus.err_count}, 32'd0);
    endtask

    initial begin
        int         wv0;
        int         se0;
        logic [3:0] qsave;
        rst           = 1'b1;
        bus.din_valid = 1'b0;
        bus.frame     = 1'b0;
        bus.din       = 1'b0;
        model_reset();
        n_wv   = 0;
        n_serr = 0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        idle(2);

        // Reset then align
        wv0 = n_wv;
        beat(1, 1); beat(0, 0); beat(0, 1); beat(0, 1);
        chk("align_q", {28'd0, bus.q3, bus.q2, bus.q1, bus.q0}, 32'hD);
        idle(1);
        chk("align_sel_wrap", {30'd0, bus.sel}, 32'd0);
        chk("align_wv_count", n_wv - wv0, 32'd1);

        // Gapped stream
        wv0 = n_wv;
        beat(1, 1); idle(3); beat(0, 0); idle(3); beat(0, 1); idle(3); beat(0, 1);
        idle(3);
        chk("gap_wv_count", n_wv - wv0, 32'd1);
        chk("gap_q", {28'd0, bus.q3, bus.q2, bus.q1, bus.q0}, 32'hD);

        // Hunt discard
        do_reset();
        se0 = n_serr;
        for (int i = 0; i < 5; i++) beat(0, 1'(i & 1));
        beat(1, 0); beat(0, 1); beat(0, 0); beat(0, 0);
        idle(1);
        chk("hunt_q", {28'd0, bus.q3, bus.q2, bus.q1, bus.q0}, 32'h2);
        chk("hunt_no_serr", n_serr - se0, 32'd0);

        // Early frame on lane 2, rebuilt word starts with that beat
        wv0 = n_wv;
        se0 = n_serr;
        beat(1, 1); beat(0, 1); beat(1, 0); beat(0, 1); beat(0, 1); beat(0, 0);
        idle(1);
        chk("early_serr", n_serr - se0, 32'd1);
        chk("early_errcnt", {28'd0, bus.err_count}, 32'd1);
        chk("early_wv_count", n_wv - wv0, 32'd1);
        chk("early_q", {28'd0, bus.q3, bus.q2, bus.q1, bus.q0}, 32'h6);

        // Missing frame at sel=0
        qsave = {bus.q3, bus.q2, bus.q1, bus.q0};
        beat(0, 1);
        chk("miss_locked", {31'd0, bus.locked}, 32'd0);
        idle(2);
        chk("miss_q_hold", {28'd0, bus.q3, bus.q2, bus.q1, bus.q0}, {28'd0, qsave});
        chk("miss_errcnt", {28'd0, bus.err_count}, 32'd2);

        // Error saturation
        for (int i = 0; i < 17; i++) begin
            beat(1, 1); beat(0, 1); beat(0, 1); beat(0, 1);
            beat(0, 0);
        end
        idle(1);
        chk("sat_errcnt", {28'd0, bus.err_count}, 32'd15);
        chk("sat_q", {28'd0, bus.q3, bus.q2, bus.q1, bus.q0}, 32'hF);

        // Async reset mid-word, between clock edges
        beat(1, 1); beat(0, 1);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);
        chk("post_rst_locked", {31'd0, bus.locked}, 32'd0);
        beat(1, 0); beat(0, 0); beat(0, 1); beat(0, 0);
        idle(2);
        chk("post_rst_q", {28'd0, bus.q3, bus.q2, bus.q1, bus.q0}, 32'h4);

        chk("sb_empty", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

`default_nettype wire
